// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared opcode/funct/ALU operation constants, FSM states and RV32IM decode
package alu_issue_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
  localparam logic [6:0] ALU_ADD    = 7'd0;
  localparam logic [6:0] ALU_SUB    = 7'd1;
  localparam logic [6:0] ALU_SLL    = 7'd2;
  localparam logic [6:0] ALU_SLT    = 7'd3;
  localparam logic [6:0] ALU_SLTU   = 7'd4;
  localparam logic [6:0] ALU_XOR    = 7'd5;
  localparam logic [6:0] ALU_SRL    = 7'd6;
  localparam logic [6:0] ALU_SRA    = 7'd7;
  localparam logic [6:0] ALU_OR     = 7'd8;
  localparam logic [6:0] ALU_AND    = 7'd9;
  localparam logic [6:0] ALU_MUL    = 7'd10;
  localparam logic [6:0] ALU_MULH   = 7'd11;
  localparam logic [6:0] ALU_MULHSU = 7'd12;
  localparam logic [6:0] ALU_MULHU  = 7'd13;
  localparam logic [6:0] ALU_DIV    = 7'd14;
  localparam logic [6:0] ALU_DIVU   = 7'd15;
  localparam logic [6:0] ALU_REM    = 7'd16;
  localparam logic [6:0] ALU_REMU   = 7'd17;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ALU     = 2'd1;
  localparam logic [1:0] ST_DIV     = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;
  typedef struct packed {
    logic        legal;
    logic [6:0]  op;
    logic [31:0] ip2;
  } dec_t;
  function automatic logic [6:0] base_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic dec_t decode(input logic [31:0] ins, input logic [31:0] rs2);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    d.legal = 1'b0;
    d.op = ALU_ADD;
    d.ip2 = rs2;
    if (ins[6:0] == OPC_OP) begin
      case (f7)
        F7_BASE: begin
          d.legal = 1'b1;
          d.op = base_op(f3);
        end
        F7_ALT: begin
          d.legal = f3 == 3'd0 || f3 == 3'd5;
          d.op = f3 == 3'd0 ? ALU_SUB : ALU_SRA;
        end
        F7_MULDIV: begin
          d.legal = 1'b1;
          d.op = ALU_MUL + {4'd0, f3};
        end
        default: d.legal = 1'b0;
      endcase
    end else if (ins[6:0] == OPC_OPIMM) begin
      d.ip2 = {{20{ins[31]}}, ins[31:20]};
      case (f3)
        3'd1: begin
          d.legal = f7 == F7_BASE;
          d.op = ALU_SLL;
          d.ip2 = {27'd0, ins[24:20]};
        end
        3'd5: begin
          d.legal = f7 == F7_BASE || f7 == F7_ALT;
          d.op = f7 == F7_ALT ? ALU_SRA : ALU_SRL;
          d.ip2 = {27'd0, ins[24:20]};
        end
        default: begin
          d.legal = 1'b1;
          d.op = base_op(f3);
        end
      endcase
    end
    return d;
  endfunction
endpackage

// File: rtl/alu_issue_div.sv
// div_iter: restoring radix-2 divider, 32 iterations with sign fix folded into the last one
module div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  logic [31:0] rem_q, quo_q, dvs_q, rem_n, quo_n;
  logic [32:0] diff;
  logic [4:0]  count;
  logic        busy, neg_q, neg_r;
  always_comb begin
    diff = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    rem_n = diff[32] ? {rem_q[30:0], quo_q[31]} : diff[31:0];
    quo_n = {quo_q[30:0], ~diff[32]};
    done = busy && count == 5'd31;
    quotient = neg_q ? -quo_n : quo_n;
    remainder = neg_r ? -rem_n : rem_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      count <= '0;
      busy <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= is_signed && dividend[31] ? -dividend : dividend;
      dvs_q <= is_signed && divisor[31] ? -divisor : divisor;
      count <= '0;
      busy <= 1'b1;
      neg_q <= is_signed && (dividend[31] ^ divisor[31]);
      neg_r <= is_signed && dividend[31];
    end else if (busy) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      count <= count + 5'd1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: decodes RV32IM OP/OP-IMM, issues to an external ALU or the iterative divider, holds result until taken
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter bit DIV_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [31:0] alu_ip1,
  output logic [31:0] alu_ip2,
  output logic [6:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_illegal
);
  logic [1:0]  state;
  dec_t        dec;
  logic        is_divop, dv_signed, dv_rem, div_zero, ovf, short_c, bypass, accept, start, div_done;
  logic        bypass_r, byp_ill, rem_r;
  logic [31:0] short_res, div_q, div_r, div_res, ip1_r, ip2_r, byp_res;
  logic [6:0]  op_r;
  always_comb begin
    dec = decode(instr, rs2_val);
    is_divop = DIV_EN && dec.legal && dec.op >= ALU_DIV;
    dv_signed = dec.op == ALU_DIV || dec.op == ALU_REM;
    dv_rem = dec.op == ALU_REM || dec.op == ALU_REMU;
    div_zero = rs2_val == '0;
    ovf = dv_signed && rs1_val == 32'h8000_0000 && rs2_val == 32'hFFFF_FFFF;
    short_c = is_divop && (div_zero || ovf);
    short_res = div_zero ? (dv_rem ? rs1_val : '1) : (dv_rem ? '0 : rs1_val);
    bypass = !dec.legal || short_c;
    in_ready = rst_n && state == ST_IDLE;
    accept = in_valid && in_ready;
    start = accept && is_divop && !short_c;
    div_res = rem_r ? div_r : div_q;
    out_valid = state == ST_DONE;
    alu_ip1 = state == ST_ALU ? ip1_r : '0;
    alu_ip2 = state == ST_ALU ? ip2_r : '0;
    alu_operation = state == ST_ALU ? op_r : ALU_ADD;
  end
  div_iter u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (rs1_val),
    .divisor   (rs2_val),
    .is_signed (dv_signed),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ip1_r <= '0;
      ip2_r <= '0;
      op_r <= ALU_ADD;
      bypass_r <= 1'b0;
      byp_ill <= 1'b0;
      byp_res <= '0;
      rem_r <= 1'b0;
      out_result <= '0;
      out_zero <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          ip1_r <= bypass ? '0 : rs1_val;
          ip2_r <= bypass ? '0 : dec.ip2;
          op_r <= bypass ? ALU_ADD : dec.op;
          bypass_r <= bypass;
          byp_ill <= !dec.legal;
          byp_res <= dec.legal ? short_res : '0;
          rem_r <= dv_rem;
          state <= start ? ST_DIV : ST_ALU;
        end
        ST_ALU: begin
          out_result <= bypass_r ? byp_res : alu_result;
          out_zero <= bypass_r ? byp_res == '0 : alu_zero;
          out_illegal <= byp_ill;
          state <= ST_DONE;
        end
        ST_DIV: if (div_done) begin
          out_result <= div_res;
          out_zero <= div_res == '0;
          out_illegal <= 1'b0;
          state <= ST_DONE;
        end
        default: if (out_ready) state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: random and directed stimulus checked every cycle against an instruction-level model
module tb_alu_issue;
  import alu_issue_pkg::*;
  typedef struct packed {
    logic [31:0] res;
    logic        ill;
    logic [5:0]  lat;
    logic        aluchk;
    logic [6:0]  op;
    logic [31:0] ip1;
    logic [31:0] ip2;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, rs1_val = '0, rs2_val = '0;
  logic        in_ready, alu_zero, out_valid, out_zero, out_illegal;
  logic [31:0] alu_ip1, alu_ip2, alu_result, out_result;
  logic [6:0]  alu_operation;
  int          checks = 0, errors = 0;
  exp_t        m_exp = '0;
  logic        m_busy = 1'b0, m_hold = 1'b0, m_rst = 1'b0;
  int          m_cnt = 0;
  always #5 clk = ~clk;
  alu_issue #(.DIV_EN(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instr         (instr),
    .rs1_val       (rs1_val),
    .rs2_val       (rs2_val),
    .alu_ip1       (alu_ip1),
    .alu_ip2       (alu_ip2),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_illegal   (out_illegal)
  );
  function automatic logic [31:0] alu_fn(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    r = '0;
    case (op)
      ALU_ADD:    r = a + b;
      ALU_SUB:    r = a - b;
      ALU_SLL:    r = a << b[4:0];
      ALU_SLT:    r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:   r = {31'd0, a < b};
      ALU_XOR:    r = a ^ b;
      ALU_SRL:    r = a >> b[4:0];
      ALU_SRA:    r = $signed(a) >>> b[4:0];
      ALU_OR:     r = a | b;
      ALU_AND:    r = a & b;
      ALU_MUL:    r = a * b;
      ALU_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      ALU_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; r = p[63:32]; end
      ALU_MULHU:  begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      default:    r = '0;
    endcase
    return r;
  endfunction
  always_comb begin
    alu_result = alu_fn(alu_operation, alu_ip1, alu_ip2);
    alu_zero = alu_result == '0;
  end
  function automatic logic [6:0] f3_op(input logic [2:0] f3, input logic m);
    case (f3)
      3'd0: return m ? ALU_MUL : ALU_ADD;
      3'd1: return m ? ALU_MULH : ALU_SLL;
      3'd2: return m ? ALU_MULHSU : ALU_SLT;
      3'd3: return m ? ALU_MULHU : ALU_SLTU;
      3'd4: return m ? ALU_DIV : ALU_XOR;
      3'd5: return m ? ALU_DIVU : ALU_SRL;
      3'd6: return m ? ALU_REM : ALU_OR;
      default: return m ? ALU_REMU : ALU_AND;
    endcase
  endfunction
  function automatic exp_t exp_f(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic legal, sg, rm, ov;
    logic [2:0] f3;
    logic [6:0] f7, op;
    logic [31:0] ip2, q, r;
    f3 = ins[14:12];
    f7 = ins[31:25];
    legal = 1'b0;
    op = ALU_ADD;
    ip2 = b;
    e = '0;
    e.lat = 6'd1;
    e.ill = 1'b1;
    e.op = ALU_ADD;
    if (ins[6:0] == 7'h33) begin
      if (f7 == 7'h00) begin legal = 1'b1; op = f3_op(f3, 1'b0); end
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin legal = 1'b1; op = f3 == 3'd0 ? ALU_SUB : ALU_SRA; end
      else if (f7 == 7'h01) begin legal = 1'b1; op = f3_op(f3, 1'b1); end
    end else if (ins[6:0] == 7'h13) begin
      ip2 = {{20{ins[31]}}, ins[31:20]};
      if (f3 == 3'd1) begin legal = f7 == 7'h00; op = ALU_SLL; ip2 = {27'd0, ins[24:20]}; end
      else if (f3 == 3'd5) begin legal = f7 == 7'h00 || f7 == 7'h20; op = f7 == 7'h20 ? ALU_SRA : ALU_SRL; ip2 = {27'd0, ins[24:20]}; end
      else begin legal = 1'b1; op = f3_op(f3, 1'b0); end
    end
    if (legal && op >= ALU_DIV) begin
      e.ill = 1'b0;
      sg = op == ALU_DIV || op == ALU_REM;
      rm = op == ALU_REM || op == ALU_REMU;
      ov = sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
      if (b == 0) begin q = '1; r = a; end
      else if (ov) begin q = a; r = '0; end
      else if (sg) begin q = 32'($signed(a) / $signed(b)); r = 32'($signed(a) % $signed(b)); end
      else begin q = a / b; r = a % b; end
      e.res = rm ? r : q;
      e.lat = (b == 0 || ov) ? 6'd1 : 6'd32;
    end else if (legal) begin
      e.ill = 1'b0;
      e.aluchk = 1'b1;
      e.op = op;
      e.ip1 = a;
      e.ip2 = ip2;
      e.res = alu_fn(op, a, ip2);
    end
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_hold <= 1'b0;
      m_rst <= 1'b1;
    end else if (m_hold) begin
      if (out_ready) m_hold <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == int'(m_exp.lat)) begin
        m_busy <= 1'b0;
        m_hold <= 1'b1;
        m_rst <= 1'b0;
      end
    end else if (in_valid) begin
      m_exp <= exp_f(instr, rs1_val, rs2_val);
      m_busy <= 1'b1;
      m_cnt <= 0;
    end
  end
  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, rst_n && !m_busy && !m_hold});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
    if (m_hold) begin
      chk("out_result", out_result, m_exp.res);
      chk("out_zero", {31'd0, out_zero}, {31'd0, m_exp.res == '0});
      chk("out_illegal", {31'd0, out_illegal}, {31'd0, m_exp.ill});
    end else if (m_rst) begin
      chk("rst_result", out_result, '0);
      chk("rst_zero", {31'd0, out_zero}, '0);
      chk("rst_illegal", {31'd0, out_illegal}, '0);
    end
    if (m_busy && m_cnt == 0 && m_exp.aluchk) begin
      chk("alu_op", {25'd0, alu_operation}, {25'd0, m_exp.op});
      chk("alu_ip1", alu_ip1, m_exp.ip1);
      chk("alu_ip2", alu_ip2, m_exp.ip2);
    end else begin
      chk("alu_op_idle", {25'd0, alu_operation}, {25'd0, ALU_ADD});
      chk("alu_ip1_idle", alu_ip1, '0);
      chk("alu_ip2_idle", alu_ip2, '0);
    end
  end
  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'h33};
  endfunction
  function automatic logic [31:0] it(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'h13};
  endfunction
  function automatic logic [31:0] rand_val();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom % 64;
      default: return $urandom;
    endcase
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] f7;
    r = $urandom;
    case ($urandom % 4)
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    case ($urandom % 4)
      0: return {f7, r[24:7], 7'h33};
      1: return {f7, r[24:7], 7'h13};
      2: return {r[31:7], 7'h13};
      default: return r;
    endcase
  endfunction
  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input logic r, input logic rs);
    @(negedge clk);
    #1;
    in_valid = v;
    instr = i;
    rs1_val = a;
    rs2_val = b;
    out_ready = r;
    rst_n = rs;
  endtask
  task automatic idle(input int n, input logic r);
    for (int k = 0; k < n; k++) drive(1'b0, '0, '0, '0, r, 1'b1);
  endtask
  initial begin
    exp_t e;
    e = exp_f(rt(7'h00, 3'd0), 32'd23, 32'd46);
    chk("model_add", e.res, 32'd69);
    chk("model_add_ip2", e.ip2, 32'd46);
    e = exp_f(32'hFFF28093, 32'd5, 32'd0);
    chk("model_addi", e.res, 32'd4);
    chk("model_addi_ip2", e.ip2, 32'hFFFF_FFFF);
    e = exp_f(it(12'd2, 3'd1), 32'd23, 32'd0);
    chk("model_slli", e.res, 32'd92);
    e = exp_f(rt(7'h01, 3'd7), 32'd654, 32'd46);
    chk("model_remu", e.res, 32'd10);
    chk("model_remu_lat", {26'd0, e.lat}, 32'd32);
    e = exp_f(rt(7'h01, 3'd4), 32'h8000_0000, 32'hFFFF_FFFF);
    chk("model_div_ovf", e.res, 32'h8000_0000);
    chk("model_div_ovf_lat", {26'd0, e.lat}, 32'd1);
    e = exp_f(rt(7'h01, 3'd5), 32'd7, 32'd0);
    chk("model_divu0", e.res, 32'hFFFF_FFFF);
    e = exp_f(rt(7'h01, 3'd6), -32'sd7, 32'd2);
    chk("model_rem_neg", e.res, 32'hFFFF_FFFF);
    e = exp_f(32'h0000_007F, 32'd9, 32'd9);
    chk("model_illegal", {31'd0, e.ill}, 32'd1);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    idle(2, 1'b1);
    drive(1'b1, rt(7'h00, 3'd0), 32'd23, 32'd46, 1'b1, 1'b1);
    idle(3, 1'b1);
    drive(1'b1, 32'hFFF28093, 32'd5, 32'd0, 1'b1, 1'b1);
    idle(3, 1'b1);
    drive(1'b1, it(12'd2, 3'd1), 32'd23, 32'd0, 1'b1, 1'b1);
    idle(3, 1'b1);
    drive(1'b1, rt(7'h01, 3'd7), 32'd654, 32'd46, 1'b1, 1'b1);
    idle(34, 1'b1);
    drive(1'b1, rt(7'h01, 3'd4), 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    idle(3, 1'b1);
    drive(1'b1, rt(7'h01, 3'd5), 32'd7, 32'd0, 1'b1, 1'b1);
    idle(3, 1'b1);
    drive(1'b1, rt(7'h01, 3'd6), -32'sd7, 32'd2, 1'b1, 1'b1);
    idle(34, 1'b1);
    drive(1'b1, rt(7'h00, 3'd4), 32'd5, 32'd3, 1'b0, 1'b1);
    idle(6, 1'b0);
    drive(1'b1, rt(7'h20, 3'd0), 32'd1, 32'd2, 1'b1, 1'b1);
    drive(1'b1, rt(7'h20, 3'd0), 32'd1, 32'd2, 1'b1, 1'b1);
    idle(3, 1'b1);
    drive(1'b1, rt(7'h01, 3'd4), 32'd100, 32'd7, 1'b1, 1'b1);
    idle(10, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    idle(40, 1'b1);
    drive(1'b1, 32'h0000_007F, 32'd9, 32'd9, 1'b1, 1'b1);
    idle(3, 1'b1);
    for (int n = 0; n < 5000; n++)
      drive(1'($urandom % 2), rand_instr(), rand_val(), rand_val(), 1'($urandom % 4 != 0), 1'($urandom % 150 != 0));
    idle(40, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: DIV_EN, 1, 1 = DIV/DIVU/REM/REMU execute in internal iterative divider; 0 = issued to ALU like other ops.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream has an instruction plus operands.
REQ-005 Port: in_ready  output  1  block accepts; transfer when in_valid && in_ready at clock edge.
REQ-006 Port: instr  input  32  RV32 instruction word.
REQ-007 Port: rs1_val, rs2_val  input  32 each  register operands.
REQ-008 Port: alu_ip1, alu_ip2  output  32 each  ALU operands.
REQ-009 Port: alu_operation  output  7  ALU operation code from shared constants.
REQ-010 Port: alu_result  input  32; alu_zero  input  1  combinational ALU return.
REQ-011 Port: out_valid  output  1; out_ready  input  1  result handshake.
REQ-012 Port: out_result  output  32; out_zero  output  1; out_illegal  output  1.

Function
REQ-013 Decode SHALL cover opcode OP (0110011) and OP-IMM (0010011) only, standard RV32I/M funct3/funct7 to matching constants code; SUB/SRA/SRAI need funct7 0100000.
REQ-014 OP-IMM SHALL set ip2 = sign-extended instr[31:20]; shift-immediates use zero-extended instr[24:20].
REQ-015 Any other opcode or funct combination SHALL complete as illegal: out_illegal=1, out_result=0, out_zero=1, latency 1.
REQ-016 FSM states IDLE, ALU, DIV, DONE; in_ready = rst_n && state==IDLE.
REQ-017 IDLE -> ALU on accept for ALU ops and illegal/short-circuit cases; IDLE -> DIV on accept for div/rem when DIV_EN=1.
REQ-018 Operands and opcode SHALL be registered at accept; alu_ip1/ip2/operation driven from registers during ALU state; result and zero captured at next edge, ALU -> DONE (latency 1).
REQ-019 Outside ALU state alu_ip1=0, alu_ip2=0, alu_operation=`ADD.
REQ-020 DIV: restoring radix-2 on magnitudes, exactly 32 iterations, one per edge; DIV -> DONE on 32nd edge; sign fix applied on that edge (quotient sign = xor, remainder sign = dividend).
REQ-021 Divide-by-zero SHALL short-circuit via ALU-state timing: DIVU -> 0xFFFFFFFF, DIV -> 0xFFFFFFFF, REM/REMU -> dividend.
REQ-022 Overflow DIV 0x80000000 / 0xFFFFFFFF SHALL short-circuit: DIV -> 0x80000000, REM -> 0.
REQ-023 For divider results out_zero = (out_result==0).
REQ-024 DONE: out_valid=1; out_result/out_zero/out_illegal held stable until out_ready; DONE -> IDLE on edge with out_ready=1.
REQ-025 No new accept while busy; one instruction in flight.

Reset
REQ-026 rst_n low at an edge SHALL force IDLE from any state, abandoning in-flight work; no output for it.
REQ-027 Reset values: out_valid=0, out_result=0, out_zero=0, out_illegal=0, alu_* per REQ-019, divider count 0; in_ready=0 while rst_n low.

Structure
REQ-028 Operation codes SHALL come from the shared constants file, no local duplicates; opcode/funct7 literals added there.
REQ-029 Iterative divider SHALL be sub-module div_iter (start, operands, signed flag, done, quotient, remainder); ALU stays external.

Verification
REQ-030 ADD x3,x1,x2 rs1=23 rs2=46 -> alu_operation=`ADD, ip1=23, ip2=46 in ALU cycle; out_result=69, out_zero=0 one cycle after accept.
REQ-031 instr 0xFFF28093 (ADDI -1) rs1=5 -> alu_ip2=0xFFFFFFFF, out_result=4; SLLI shamt 2 rs1=23 -> 92.
REQ-032 REMU rs1=654 rs2=46, DIV_EN=1 -> out_result=10, out_valid exactly 32 edges after accept, alu_operation=`ADD throughout.
REQ-033 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; DIVU 7/0 -> 0xFFFFFFFF; REM -7/2 -> 0xFFFFFFFF; all boundary cases latency 1.
REQ-034 out_ready low 5 cycles in DONE -> outputs stable, in_ready=0; release -> IDLE next edge, back-to-back accept works.
REQ-035 rst_n low at iteration 10 of DIV -> IDLE, out_valid never rises; instr 0x0000007F -> out_illegal=1, out_result=0.
